// File: rtl/axilm_rd_arb.sv
// axilm_rd_arb: round-robin arbiter sharing one AXI-Lite read-channel master between NUM_REQ requesters.
// Optional read watchdog in WAIT is enabled by defining AXILM_RD_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module axilm_rd_arb #(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [NUM_REQ-1:0]    REQ,
    input  logic [32*NUM_REQ-1:0] REQ_ADDR,
    output logic [NUM_REQ-1:0]    ACK,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  BUSY,
    output logic [IDW-1:0]        GRANT_ID,
    output logic                  M_ENA,
    output logic [3:0]            M_WSTB,
    output logic [31:0]           M_ADDR,
    input  logic                  M_DONE,
    input  logic [31:0]           M_RDATA,
    input  logic [1:0]            M_RRESP
`ifdef AXILM_RD_ARB_TIMEOUT_EN
    ,
    output logic                  TIMEOUT_ERR
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic [31:0]          win_addr;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [IDW-1:0]       ptr_next;
    int                   scan_idx;

`ifdef AXILM_RD_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;
`endif

    // Rotating priority search: first requester at or above the pointer, wrapping around.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!win_found && REQ[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_idx);
                win_addr  = REQ_ADDR[32*scan_idx +: 32];
            end
        end
    end

    always_comb begin
        grant_onehot           = '0;
        grant_onehot[GRANT_ID] = 1'b1;
    end

    assign ptr_next = (GRANT_ID == IDW'(NUM_REQ - 1)) ? '0 : GRANT_ID + 1'b1;

    // NOTE: state and registered outputs use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            ACK      <= '0;
            RDATA    <= '0;
            RRESP    <= 2'b00;
            BUSY     <= 1'b0;
            GRANT_ID <= '0;
            M_ENA    <= 1'b0;
            M_WSTB   <= 4'b0000;
            M_ADDR   <= '0;
`ifdef AXILM_RD_ARB_TIMEOUT_EN
            wd_cnt      <= '0;
            TIMEOUT_ERR <= 1'b0;
`endif
        end else begin
            M_WSTB <= 4'b0000;
            case (state)
                ST_IDLE: begin
                    ACK <= '0;
                    if (win_found) begin
                        GRANT_ID <= win_idx;
                        M_ADDR   <= win_addr;
                        M_ENA    <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end

                // The strobe is already high for this cycle; any M_DONE here is ignored.
                ST_ISSUE: begin
                    M_ENA <= 1'b0;
                    state <= ST_WAIT;
`ifdef AXILM_RD_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end

                ST_WAIT: begin
                    if (M_DONE) begin
                        RDATA <= M_RDATA;
                        RRESP <= M_RRESP;
                        ACK   <= grant_onehot;
                        state <= ST_RESP;
                    end
`ifdef AXILM_RD_ARB_TIMEOUT_EN
                    else if (wd_cnt == WDW'(TIMEOUT_CYCLES)) begin
                        RDATA       <= 32'h0000_0000;
                        RRESP       <= 2'b10;
                        ACK         <= grant_onehot;
                        TIMEOUT_ERR <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                ST_RESP: begin
                    ACK   <= '0;
                    ptr   <= ptr_next;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    ACK   <= '0;
                    M_ENA <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilm_rd_arb.sv
// tb_axilm_rd_arb: directed and randomized checks of axilm_rd_arb against a transaction-level model.
// Define AXILM_RD_ARB_TIMEOUT_EN to also exercise the read watchdog.
`timescale 1ns/1ps

module tb_axilm_rd_arb;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic [N-1:0]   REQ;
    logic [32*N-1:0] REQ_ADDR;
    logic [N-1:0]   ACK;
    logic [31:0]    RDATA;
    logic [1:0]     RRESP;
    logic           BUSY;
    logic [IDW-1:0] GRANT_ID;
    logic           M_ENA;
    logic [3:0]     M_WSTB;
    logic [31:0]    M_ADDR;
    logic           M_DONE;
    logic [31:0]    M_RDATA;
    logic [1:0]     M_RRESP;
`ifdef AXILM_RD_ARB_TIMEOUT_EN
    logic           TIMEOUT_ERR;
`endif

    axilm_rd_arb #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .ACK      (ACK),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .BUSY     (BUSY),
        .GRANT_ID (GRANT_ID),
        .M_ENA    (M_ENA),
        .M_WSTB   (M_WSTB),
        .M_ADDR   (M_ADDR),
        .M_DONE   (M_DONE),
        .M_RDATA  (M_RDATA),
        .M_RRESP  (M_RRESP)
`ifdef AXILM_RD_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_ERR (TIMEOUT_ERR)
`endif
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference state
    int          ptr_m;
    logic [31:0] rdata_m;
    logic [1:0]  rresp_m;
    logic [31:0] addr_m [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting index at or after the pointer, modulo N.
    function automatic int model_winner(input int p, input logic [N-1:0] pat);
        for (int k = 0; k < N; k++) begin
            if (pat[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_addrs();
        for (int i = 0; i < N; i++) REQ_ADDR[32*i +: 32] = addr_m[i];
    endtask

    task automatic randomize_addrs();
        for (int i = 0; i < N; i++) addr_m[i] = $urandom & 32'hFFFF_FFFC;
        drive_addrs();
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic do_txn(input logic [N-1:0] pat, input int lat, input logic [31:0] data,
                          input logic [1:0] resp, input bit drop_early, input bit done_in_issue);
        int w;
        logic [N-1:0] oh;
        w  = model_winner(ptr_m, pat);
        oh = '0;
        oh[w] = 1'b1;
        REQ = pat;
        @(negedge ACLK);
        check("issue_m_ena", 32'(M_ENA), 32'd1);
        check("issue_busy", 32'(BUSY), 32'd1);
        check("issue_grant", 32'(GRANT_ID), 32'(w));
        check("issue_m_addr", M_ADDR, addr_m[w]);
        check("issue_m_wstb", 32'(M_WSTB), 32'd0);
        if (done_in_issue) begin
            M_DONE  = 1'b1;
            M_RDATA = ~data;
            M_RRESP = ~resp;
        end
        if (drop_early) REQ = REQ & ~oh;
        for (int c = 0; c < lat; c++) begin
            @(negedge ACLK);
            M_DONE = 1'b0;
            check("wait_m_ena", 32'(M_ENA), 32'd0);
            check("wait_ack", 32'(ACK), 32'd0);
            check("wait_m_addr", M_ADDR, addr_m[w]);
        end
        M_DONE  = 1'b1;
        M_RDATA = data;
        M_RRESP = resp;
        @(negedge ACLK);
        M_DONE  = 1'b0;
        M_RDATA = $urandom;
        M_RRESP = 2'($urandom);
        check("resp_ack", 32'(ACK), 32'(oh));
        check("resp_rdata", RDATA, data);
        check("resp_rresp", 32'(RRESP), 32'(resp));
        check("resp_busy", 32'(BUSY), 32'd1);
        REQ     = REQ & ~oh;
        ptr_m   = (w + 1) % N;
        rdata_m = data;
        rresp_m = resp;
        @(negedge ACLK);
        check("idle_ack", 32'(ACK), 32'd0);
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_rdata_hold", RDATA, rdata_m);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ACK), 32'd0);
        check({tag, "_rdata"}, RDATA, 32'd0);
        check({tag, "_rresp"}, 32'(RRESP), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_grant"}, 32'(GRANT_ID), 32'd0);
        check({tag, "_m_ena"}, 32'(M_ENA), 32'd0);
        check({tag, "_m_addr"}, M_ADDR, 32'd0);
        check({tag, "_m_wstb"}, 32'(M_WSTB), 32'd0);
    endtask

    initial begin
        ARESET   = 1'b1;
        REQ      = '0;
        REQ_ADDR = '0;
        M_DONE   = 1'b0;
        M_RDATA  = '0;
        M_RRESP  = '0;
        ptr_m    = 0;
        rdata_m  = '0;
        rresp_m  = '0;
        for (int i = 0; i < N; i++) addr_m[i] = 32'h0000_0100 * (i + 1);
        drive_addrs();
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
`ifdef AXILM_RD_ARB_TIMEOUT_EN
        check("reset_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
`endif
        ARESET = 1'b0;
        @(negedge ACLK);
        check_reset_outputs("post_reset");

        // Single read from requester 2
        addr_m[2] = 32'h0000_1000;
        drive_addrs();
        do_txn(4'b0100, 4, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0);
        check("single_grant", 32'(GRANT_ID), 32'd2);
        check("single_rdata", RDATA, 32'hDEAD_BEEF);

        // Stray M_DONE in IDLE must not produce an ACK or disturb RDATA
        M_DONE  = 1'b1;
        M_RDATA = 32'h1234_5678;
        M_RRESP = 2'b11;
        @(negedge ACLK);
        M_DONE = 1'b0;
        check("stray_ack", 32'(ACK), 32'd0);
        check("stray_busy", 32'(BUSY), 32'd0);
        @(negedge ACLK);
        check("stray_ack2", 32'(ACK), 32'd0);
        check("stray_rdata", RDATA, 32'hDEAD_BEEF);
        check("stray_rresp", 32'(RRESP), 32'd0);

        // Serve requester 3 so the pointer wraps to 0, then rotate over all four
        do_txn(4'b1000, 2, 32'hA5A5_0003, 2'b01, 1'b0, 1'b0);
        check("wrap3_grant", 32'(GRANT_ID), 32'd3);
        begin
            logic [N-1:0] pend;
            pend = 4'b1111;
            for (int g = 0; g < N; g++) begin
                do_txn(pend, 1 + g, 32'hC0DE_0000 + 32'(g), 2'(g), 1'b0, 1'b0);
                check("rr_grant", 32'(GRANT_ID), 32'(g));
                pend[g] = 1'b0;
            end
        end

        // Pointer wrap with requesters 0 and 3 both pending
        do_txn(4'b1001, 2, 32'h0000_0A00, 2'b00, 1'b0, 1'b0);
        check("wrap_first", 32'(GRANT_ID), 32'd0);
        do_txn(4'b1001, 2, 32'h0000_0A03, 2'b00, 1'b0, 1'b0);
        check("wrap_second", 32'(GRANT_ID), 32'd3);

        // Requester 1 drops REQ right after the grant; ACK must still arrive
        do_txn(4'b0010, 3, 32'h0000_B001, 2'b11, 1'b1, 1'b0);
        check("drop_grant", 32'(GRANT_ID), 32'd1);

        // M_DONE coincident with M_ENA is ignored
        do_txn(4'b0100, 2, 32'h0000_E5E5, 2'b01, 1'b0, 1'b1);

        // Asynchronous reset in the middle of WAIT
        REQ = 4'b0010;
        @(negedge ACLK);
        @(negedge ACLK);
        check("midwait_busy", 32'(BUSY), 32'd1);
        #2 ARESET = 1'b1;
        #1;
        check_reset_outputs("midwait_reset");
        REQ = '0;
        @(negedge ACLK);
        check("midwait_ack", 32'(ACK), 32'd0);
        ARESET  = 1'b0;
        ptr_m   = 0;
        rdata_m = '0;
        rresp_m = '0;
        @(negedge ACLK);
        do_txn(4'b0001, 2, 32'h0000_5EED, 2'b00, 1'b0, 1'b0);
        check("after_reset_grant", 32'(GRANT_ID), 32'd0);

        // Randomized traffic against the model
        for (int t = 0; t < 24; t++) begin
            randomize_addrs();
            do_txn(4'($urandom_range(1, 15)), int'($urandom_range(1, 5)), $urandom,
                   2'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef AXILM_RD_ARB_TIMEOUT_EN
        // Watchdog: no M_DONE, expect SLVERR ACK nine cycles after entering WAIT
        begin
            int w;
            logic [N-1:0] oh;
            w  = model_winner(ptr_m, 4'b0100);
            oh = '0;
            oh[w] = 1'b1;
            REQ = 4'b0100;
            @(negedge ACLK);
            check("to_m_ena", 32'(M_ENA), 32'd1);
            REQ = '0;
            for (int c = 0; c < 9; c++) begin
                @(negedge ACLK);
                check("to_wait_ack", 32'(ACK), 32'd0);
            end
            @(negedge ACLK);
            check("to_ack", 32'(ACK), 32'(oh));
            check("to_rresp", 32'(RRESP), 32'd2);
            check("to_rdata", RDATA, 32'd0);
            check("to_err", 32'(TIMEOUT_ERR), 32'd1);
            ptr_m = (w + 1) % N;
            @(negedge ACLK);
            check("to_idle_busy", 32'(BUSY), 32'd0);
            check("to_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
